// File: rtl/ksa_shuffle_param_pkg.sv
// Shared types and constants for the parametrised RC4 key-scheduling engine.
// KSA_INIT_EN adds the INIT state (built-in identity fill of the S-box).
package ksa_pkg;

  localparam int KEY_BYTE_W = 8;
  localparam int ITER_CYC   = 6;

  typedef enum logic [3:0] {
    IDLE,
`ifdef KSA_INIT_EN
    INIT,
`endif
    RD_I,
    LAT_I,
    RD_J,
    LAT_J,
    WR_I,
    WR_J,
    DONE
  } ksa_state_t;

endpackage

// File: rtl/ksa_shuffle_param_if.sv
// Single-port S-box RAM bus: the engine is master, the RAM is slave.
interface ksa_shuffle_param_if #(
  parameter int ADDR_W = 8
) ();

  logic              write;
  logic [ADDR_W-1:0] address;
  logic [ADDR_W-1:0] data;
  logic [ADDR_W-1:0] q;

  modport master (output write, output address, output data, input q);
  modport slave  (input write, input address, input data, output q);

endinterface

// File: rtl/ksa_shuffle_param_key_sel.sv
// Key byte mux: selects byte [kidx] (byte 0 = MSB) and truncates it to ADDR_W bits.
module ksa_key_sel
  import ksa_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int ADDR_W    = 8,
  parameter int KIDX_W    = 2
) (
  input  logic [KEY_BYTES*KEY_BYTE_W-1:0] key,
  input  logic [KIDX_W-1:0]               kidx,
  output logic [ADDR_W-1:0]               kb
);

  logic [KEY_BYTE_W-1:0] byte_sel;

  always_comb begin
    byte_sel = '0;
    for (int unsigned b = 0; b < KEY_BYTES; b++) begin
      if (kidx == KIDX_W'(b))
        byte_sel = key[(KEY_BYTES-1-b)*KEY_BYTE_W +: KEY_BYTE_W];
    end
    kb = byte_sel[ADDR_W-1:0];
  end

endmodule

// File: rtl/ksa_shuffle_param.sv
// RC4 KSA engine over a 2^ADDR_W-entry S-box held in an external single-port RAM.
// Define KSA_INIT_EN to fill s[i]=i before the shuffle; otherwise RAM must be pre-initialised.
module ksa_shuffle_param
  import ksa_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int ADDR_W    = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [KEY_BYTES*KEY_BYTE_W-1:0] secret_key,
  output logic                            done,
  ksa_shuffle_param_if.master             ram
);

  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [ADDR_W-1:0] LAST = '1;
  localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);

  ksa_state_t state, state_nxt;

  logic [ADDR_W-1:0]               i, j, si, sj, kb, j_new;
  logic [KIDX_W-1:0]               kidx;
  logic [KEY_BYTES*KEY_BYTE_W-1:0] key;

  ksa_key_sel #(
    .KEY_BYTES (KEY_BYTES),
    .ADDR_W    (ADDR_W),
    .KIDX_W    (KIDX_W)
  ) u_key_sel (
    .key  (key),
    .kidx (kidx),
    .kb   (kb)
  );

  // ADDR_W-wide sum gives the mod-N wrap for free
  assign j_new = j + si + kb;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      si    <= '0;
      sj    <= '0;
      kidx  <= '0;
      key   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            key  <= secret_key;
            i    <= '0;
            j    <= '0;
            kidx <= '0;
          end
        end
`ifdef KSA_INIT_EN
        INIT:  i  <= i + ADDR_W'(1);
`endif
        LAT_I: si <= ram.q;
        RD_J:  j  <= j_new;
        LAT_J: sj <= ram.q;
        WR_J: begin
          if (i != LAST) begin
            i    <= i + ADDR_W'(1);
            kidx <= (kidx == KIDX_LAST) ? '0 : kidx + KIDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from registered state only, so an async reset clears them at once
  always_comb begin
    state_nxt   = state;
    ram.write   = 1'b0;
    ram.address = '0;
    ram.data    = '0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef KSA_INIT_EN
          state_nxt = INIT;
`else
          state_nxt = RD_I;
`endif
        end
      end
`ifdef KSA_INIT_EN
      INIT: begin
        ram.write   = 1'b1;
        ram.address = i;
        ram.data    = i;
        if (i == LAST) state_nxt = RD_I;
      end
`endif
      RD_I: begin
        ram.address = i;
        state_nxt   = LAT_I;
      end
      LAT_I: state_nxt = RD_J;
      RD_J: begin
        ram.address = j_new;
        state_nxt   = LAT_J;
      end
      LAT_J: state_nxt = WR_I;
      WR_I: begin
        ram.write   = 1'b1;
        ram.address = i;
        ram.data    = sj;
        state_nxt   = WR_J;
      end
      WR_J: begin
        ram.write   = 1'b1;
        ram.address = j;
        ram.data    = si;
        state_nxt   = (i == LAST) ? DONE : RD_I;
      end
      DONE: begin
        done = 1'b1;
        if (!start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ksa_shuffle_param.sv
// Scoreboard bench for ksa_shuffle_param: two instances (3-byte/256-entry and 5-byte/16-entry)
// each driving a behavioural 1-cycle-read RAM; expected writes are queued by a software KSA model.
module tb_ksa_shuffle_param;
  import ksa_pkg::*;

`ifdef KSA_INIT_EN
  localparam int INIT_CYC = 1;
`else
  localparam int INIT_CYC = 0;
`endif

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic        preload = 1'b0;
  logic        start8  = 1'b0;
  logic        start4  = 1'b0;
  logic [23:0] key8    = '0;
  logic [39:0] key4    = '0;
  logic        done8, done4;

  int checks   = 0;
  int failures = 0;

  int exp8[$];
  int exp4[$];
  int wlog8[$];
  int mdl[2][256];

  logic [7:0] ram8[256];
  logic [3:0] ram4[16];

  ksa_shuffle_param_if #(.ADDR_W(8)) bus8 ();
  ksa_shuffle_param_if #(.ADDR_W(4)) bus4 ();

  ksa_shuffle_param #(.KEY_BYTES(3), .ADDR_W(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .secret_key(key8), .done(done8), .ram(bus8)
  );

  ksa_shuffle_param #(.KEY_BYTES(5), .ADDR_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .secret_key(key4), .done(done4), .ram(bus4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 256; k++) ram8[k] <= 8'(k);
      for (int k = 0; k < 16; k++)  ram4[k] <= 4'(k);
    end else begin
      if (bus8.write) ram8[bus8.address] <= bus8.data;
      if (bus4.write) ram4[bus4.address] <= bus4.data;
    end
    bus8.q <= ram8[bus8.address];
    bus4.q <= ram4[bus4.address];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (bus8.write === 1'b1) begin
      wlog8.push_back(int'({bus8.address, bus8.data}));
      if (exp8.size() == 0) check_eq("wr8_unexpected", 32'(bus8.write), 32'd0);
      else                  check_eq("wr8", 32'({bus8.address, bus8.data}), 32'(exp8.pop_front()));
    end
    if (bus4.write === 1'b1) begin
      if (exp4.size() == 0) check_eq("wr4_unexpected", 32'(bus4.write), 32'd0);
      else                  check_eq("wr4", 32'({bus4.address, bus4.data}), 32'(exp4.pop_front()));
    end
  end

  task automatic push_exp(input int sel, input int v);
    if (sel == 0) exp8.push_back(v);
    else          exp4.push_back(v);
  endtask

  // Reference KSA: queues every RAM write in order and advances the model S-box
  task automatic model_run(input int sel, input int n, input logic [39:0] key, input int kbytes);
    int s[256];
    int j, kb, t;
    for (int k = 0; k < n; k++) s[k] = mdl[sel][k];
`ifdef KSA_INIT_EN
    for (int k = 0; k < n; k++) begin
      s[k] = k;
      push_exp(sel, k * n + k);
    end
`endif
    j = 0;
    for (int i = 0; i < n; i++) begin
      kb = int'((key >> (8 * (kbytes - 1 - (i % kbytes)))) & 40'hFF) & (n - 1);
      j  = (j + s[i] + kb) % n;
      push_exp(sel, i * n + s[j]);
      push_exp(sel, j * n + s[i]);
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    for (int k = 0; k < n; k++) mdl[sel][k] = s[k];
  endtask

  task automatic set_identity(input int sel);
    for (int k = 0; k < 256; k++) mdl[sel][k] = k;
  endtask

  function automatic logic cur_done(input int sel);
    return (sel == 0) ? done8 : done4;
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start8 = v;
    else          start4 = v;
  endtask

  task automatic check_ram(input int sel, input int n);
    int seen[256];
    int mism = 0;
    int dup  = 0;
    int v;
    for (int k = 0; k < 256; k++) seen[k] = 0;
    for (int k = 0; k < n; k++) begin
      v = (sel == 0) ? int'(ram8[k]) : int'(ram4[k]);
      if (v != mdl[sel][k]) mism++;
      seen[v]++;
    end
    for (int k = 0; k < n; k++) if (seen[k] != 1) dup++;
    check_eq((sel == 0) ? "ram8_model" : "ram4_model", 32'(mism), 32'd0);
    check_eq((sel == 0) ? "ram8_perm" : "ram4_perm", 32'(dup), 32'd0);
  endtask

  task automatic do_run(input int sel, input logic [39:0] key, input int kbytes, input int n);
    int cnt;
    wlog8.delete();
    model_run(sel, n, key, kbytes);
    @(negedge clk);
    if (sel == 0) key8 = key[23:0];
    else          key4 = key;
    set_start(sel, 1'b1);
    @(posedge clk);
    #1;
    // key scrambled after the start edge must not affect the result
    if (sel == 0) key8 = ~key8;
    else          key4 = ~key4;
    cnt = 0;
    while (cur_done(sel) !== 1'b1 && cnt < 8 * n + 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check_eq((sel == 0) ? "done8_latency" : "done4_latency", 32'(cnt), 32'(n * (ITER_CYC + INIT_CYC)));
    repeat (8) @(posedge clk);
    #1;
    check_eq("done_held", 32'(cur_done(sel)), 32'd1);
    @(negedge clk);
    set_start(sel, 1'b0);
    @(posedge clk);
    #1;
    check_eq("done_drop", 32'(cur_done(sel)), 32'd0);
    check_eq("exp_drained", 32'((sel == 0) ? exp8.size() : exp4.size()), 32'd0);
    check_ram(sel, n);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    set_identity(0);
    set_identity(1);
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_outs8", 32'({done8, bus8.write, bus8.address, bus8.data}), 32'd0);
    check_eq("reset_outs4", 32'({done4, bus4.write, bus4.address, bus4.data}), 32'd0);
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    reset   = 1'b1;

    // 3-byte key over 256 entries, then a held-start rerun from the resulting state
    do_run(0, 40'h0000000249, 3, 256);
    base = INIT_CYC * 256;
    check_eq("wlog_count", 32'(wlog8.size()), 32'(base + 512));
`ifdef KSA_INIT_EN
    check_eq("init_first", 32'(wlog8[0]), 32'h0000);
    check_eq("init_last", 32'(wlog8[255]), 32'hFFFF);
`endif
    check_eq("i1_wr_i", 32'(wlog8[base + 2]), 32'h0103);
    check_eq("i1_wr_j", 32'(wlog8[base + 3]), 32'h0301);
    check_eq("i2_wr_i", 32'(wlog8[base + 4]), 32'h024E);
    check_eq("i2_wr_j", 32'(wlog8[base + 5]), 32'h4E02);
    do_run(0, 40'h0000000249, 3, 256);

    // 5-byte key, 16-entry S-box: key index wraps after byte 4
    do_run(1, 40'h0102030405, 5, 16);

    // abort mid-shuffle at i=100
    model_run(0, 256, 40'h0000000249, 3);
    @(negedge clk);
    key8   = 24'h000249;
    start8 = 1'b1;
    @(posedge clk);
    repeat (INIT_CYC * 256 + 100 * ITER_CYC + 2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check_eq("abort_outs", 32'({done8, bus8.write, bus8.address, bus8.data}), 32'd0);
    exp8.delete();
    start8 = 1'b0;
    @(negedge clk);
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    reset   = 1'b1;
    set_identity(0);
    do_run(0, 40'h0000000249, 3, 256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
